// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised distributed RAM and its init sequencer.
package ram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } init_state_e;

   function automatic int unsigned bw(input int unsigned width);
      return width / 8;
   endfunction

   function automatic bit width_ok(input int unsigned width);
      return (width % 8) == 0;
   endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: walks every address once after reset or on request, driving the fill write.
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int unsigned ADD_BITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                init_req,
   output logic                init_busy,
   output logic                init_we,
   output logic [ADD_BITS-1:0] init_addr
);

   localparam int unsigned DEPTH = 2 ** ADD_BITS;
   localparam logic [ADD_BITS:0] CNT_LAST = (ADD_BITS + 1)'(DEPTH - 1);

   init_state_e       state_q, state_d;
   logic [ADD_BITS:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (init_req) begin
               cnt_d   = '0;
               state_d = ST_INIT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign init_busy = (state_q == ST_INIT);
   assign init_we   = init_busy;
   assign init_addr = cnt_q[ADD_BITS-1:0];

endmodule

// File: rtl/dist_ram_dp_param.sv
// Simple dual-port distributed RAM with byte enables, optional registered read with
// write-first bypass, and a built-in fill sequencer.
module dist_ram_dp_param
   import ram_pkg::*;
#(
   parameter int unsigned            RAM_WIDTH = 8,
   parameter int unsigned            ADD_BITS  = 5,
   parameter bit                     REG_OUT   = 1'b1,
   parameter bit                     BYPASS    = 1'b1,
   parameter logic [RAM_WIDTH-1:0]   INIT_VAL  = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      write_sig,
   input  logic [bw(RAM_WIDTH)-1:0]  byte_en,
   input  logic [ADD_BITS-1:0]       address_w,
   input  logic [RAM_WIDTH-1:0]      data_in,
   input  logic                      read_en,
   input  logic [ADD_BITS-1:0]       address_r,
   output logic [RAM_WIDTH-1:0]      data_out,
   output logic                      data_valid,
   input  logic                      init_req,
   output logic                      init_busy
);

   localparam int unsigned NB    = bw(RAM_WIDTH);
   localparam int unsigned DEPTH = 2 ** ADD_BITS;

   if (!width_ok(RAM_WIDTH)) begin : g_bad_width
      $error("RAM_WIDTH must be a multiple of 8");
   end

   logic                 init_we;
   logic [ADD_BITS-1:0]  init_addr;
   logic                 user_we;
   logic                 wr_en;
   logic [NB-1:0]        wr_be;
   logic [ADD_BITS-1:0]  wr_addr;
   logic [RAM_WIDTH-1:0] wr_data;
   logic [RAM_WIDTH-1:0] rd_word;

   // No reset on the array so it maps onto LUT RAM.
   logic [RAM_WIDTH-1:0] mem [DEPTH];

   ram_init_seq #(
      .ADD_BITS (ADD_BITS)
   ) u_init_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_req  (init_req),
      .init_busy (init_busy),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   assign user_we = write_sig & ~init_busy;

   always_comb begin
      if (init_we) begin
         wr_en   = 1'b1;
         wr_be   = '1;
         wr_addr = init_addr;
         wr_data = INIT_VAL;
      end else begin
         wr_en   = user_we;
         wr_be   = byte_en;
         wr_addr = address_w;
         wr_data = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_word = mem[address_r];

   if (REG_OUT) begin : g_reg_out
      logic [RAM_WIDTH-1:0] dout_q, dout_d, byp_word;
      logic                 valid_q, valid_d, rd_fire;

      always_comb begin
         byp_word = rd_word;
         // Write-first: merge enabled bytes of the colliding write into the read word.
         if (BYPASS && user_we && (address_w == address_r)) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (byte_en[i]) byp_word[8*i +: 8] = data_in[8*i +: 8];
            end
         end
         rd_fire = read_en & ~init_busy;
         dout_d  = rd_fire ? byp_word : dout_q;
         valid_d = rd_fire;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
         end
      end

      assign data_out   = dout_q;
      assign data_valid = valid_q;
   end else begin : g_comb_out
      assign data_out   = rd_word;
      assign data_valid = read_en & ~init_busy;
   end

endmodule
